// File: rtl/nios2system_led_fader.sv
// nios2system_led_fader: ramps 10 PIO LED requests through a shared PWM under Avalon-MM control; NIOS2SYSTEM_LED_FADER_STATUS_EN adds STATUS compare
module nios2system_led_fader #(
  parameter int PWM_BITS = 8,
  parameter int DIV_BITS = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [9:0]  led_in,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [9:0]  led_out
);
  localparam logic [PWM_BITS-1:0] pwm_top = PWM_BITS'((2 ** PWM_BITS) - 2);
  localparam logic [PWM_BITS-1:0] lvl_one = PWM_BITS'(1);
  localparam logic [DIV_BITS-1:0] div_one = DIV_BITS'(1);
  logic                fade_en;
  logic [DIV_BITS-1:0] step_div;
  logic [DIV_BITS-1:0] step_cnt;
  logic [PWM_BITS-1:0] max_level;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [9:0]          led_in_q;
  logic [PWM_BITS-1:0] level [10];
  logic [PWM_BITS-1:0] target [10];
  logic [PWM_BITS-1:0] next_level [10];
  logic [31:0]         status_word;
  logic                wr;
  logic                wr_ctrl;
  logic                wr_div;
  logic                wr_max;
  logic                tick;
  logic                fade_now;
  assign wr       = chipselect && !write_n;
  assign wr_ctrl  = wr && (address == 2'd0);
  assign wr_div   = wr && (address == 2'd1);
  assign wr_max   = wr && (address == 2'd3);
  assign tick     = step_cnt == step_div;
  assign fade_now = wr_ctrl ? writedata[0] : fade_en;
  always_comb begin
    for (int i = 0; i < 10; i++) begin
      target[i]     = led_in_q[i] ? max_level : '0;
      next_level[i] = !fade_now ? target[i] :
                      !tick ? level[i] :
                      (level[i] < target[i]) ? level[i] + lvl_one :
                      (level[i] > target[i]) ? level[i] - lvl_one : level[i];
    end
  end
`ifdef NIOS2SYSTEM_LED_FADER_STATUS_EN
  logic [9:0] settled;
  always_comb begin
    for (int i = 0; i < 10; i++) settled[i] = level[i] == target[i];
  end
  assign status_word = {22'b0, settled};
`else
  assign status_word = 32'b0;
`endif
  assign readdata = (address == 2'd0) ? {31'b0, fade_en} :
                    (address == 2'd1) ? 32'(step_div) :
                    (address == 2'd2) ? status_word : 32'(max_level);
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fade_en   <= 1'b1;
      step_div  <= DIV_BITS'(1000);
      max_level <= '1;
      step_cnt  <= '0;
      pwm_cnt   <= '0;
      led_in_q  <= '0;
      led_out   <= '0;
      for (int i = 0; i < 10; i++) level[i] <= '0;
    end else begin
      if (wr_ctrl) fade_en <= writedata[0];
      if (wr_div) step_div <= writedata[DIV_BITS-1:0];
      if (wr_max) max_level <= writedata[PWM_BITS-1:0];
      step_cnt <= (wr_div || tick) ? '0 : step_cnt + div_one;
      pwm_cnt  <= (pwm_cnt == pwm_top) ? '0 : pwm_cnt + lvl_one;
      led_in_q <= led_in;
      for (int i = 0; i < 10; i++) begin
        level[i]   <= next_level[i];
        led_out[i] <= pwm_cnt < level[i];
      end
    end
  end
endmodule

// File: tb/tb_nios2system_led_fader.sv
// tb_nios2system_led_fader: directed plus randomized checks of the LED fader against a behavioural model
module tb_nios2system_led_fader;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [9:0]  led_in = '0;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [9:0]  led_out;
  int checks = 0;
  int failures = 0;
  int m_lv [10];
  int m_pc, m_sc, m_dv, m_mx;
  bit m_fe;
  logic [9:0] m_lq, m_lo;
  always #5 clk = ~clk;
  nios2system_led_fader dut (
    .clk(clk), .reset_n(reset_n), .led_in(led_in), .address(address),
    .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
    .readdata(readdata), .led_out(led_out)
  );
  function automatic logic [31:0] m_read(input logic [1:0] a);
    logic [31:0] st = '0;
`ifdef NIOS2SYSTEM_LED_FADER_STATUS_EN
    for (int i = 0; i < 10; i++) st[i] = (m_lv[i] == (m_lq[i] ? m_mx : 0));
`endif
    case (a)
      2'd0: return {31'b0, m_fe};
      2'd1: return 32'(m_dv);
      2'd2: return st;
      default: return 32'(m_mx);
    endcase
  endfunction
  task automatic model_edge();
    bit w, t, fe;
    int tgt;
    if (!reset_n) begin
      for (int i = 0; i < 10; i++) m_lv[i] = 0;
      m_pc = 0; m_sc = 0; m_dv = 1000; m_mx = 255; m_fe = 1; m_lq = '0; m_lo = '0;
      return;
    end
    w  = chipselect && !write_n;
    t  = (m_sc == m_dv);
    fe = (w && address == 2'd0) ? writedata[0] : m_fe;
    for (int i = 0; i < 10; i++) begin
      tgt = m_lq[i] ? m_mx : 0;
      m_lo[i] = (m_pc < m_lv[i]);
      if (!fe) m_lv[i] = tgt;
      else if (t) m_lv[i] += (m_lv[i] < tgt) ? 1 : (m_lv[i] > tgt) ? -1 : 0;
    end
    m_pc = (m_pc == 254) ? 0 : m_pc + 1;
    m_sc = (t || (w && address == 2'd1)) ? 0 : m_sc + 1;
    if (w && address == 2'd0) m_fe = writedata[0];
    if (w && address == 2'd1) m_dv = int'(writedata[15:0]);
    if (w && address == 2'd3) m_mx = int'(writedata[7:0]);
    m_lq = led_in;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    chk("led_out", 32'(led_out), 32'(m_lo));
  endtask
  task automatic run(input int n);
    repeat (n) cyc();
  endtask
  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    cyc();
    chipselect = 1'b0; write_n = 1'b1;
  endtask
  task automatic rd(input logic [1:0] a, input string tag);
    address = a;
    #1;
    chk(tag, readdata, m_read(a));
  endtask
  task automatic timeout(input string tag);
    failures++;
    $display("FAIL %s timeout observed=expired expected=reached", tag);
  endtask
  initial begin
    int n, cnt;
    logic [9:0] acc;
    run(3);
    reset_n = 1'b1;
    address = 2'd0; #1; chk("rst_ctrl", readdata, 32'd1);
    address = 2'd1; #1; chk("rst_div", readdata, 32'd1000);
    address = 2'd3; #1; chk("rst_max", readdata, 32'd255);
`ifdef NIOS2SYSTEM_LED_FADER_STATUS_EN
    address = 2'd2; #1; chk("rst_status", readdata, 32'h3FF);
`else
    address = 2'd2; #1; chk("rst_status", readdata, 32'h0);
`endif
    acc = '0;
    repeat (600) begin cyc(); acc |= led_out; end
    chk("idle_dark", 32'(acc), 32'h0);
    wr_reg(2'd1, 32'd0);
    led_in = 10'h001;
    run(262);
    cnt = 0; acc = '0;
    repeat (255) begin cyc(); cnt += int'(led_out[0]); acc |= {led_out[9:1], 1'b0}; end
    chk("full_on_duty", 32'(cnt), 32'd255);
    chk("others_off", 32'(acc), 32'h0);
    led_in = 10'h000;
    run(262);
    wr_reg(2'd1, 32'd3);
    led_in = 10'h001;
    n = 0;
    while (m_lv[0] != 100 && n < 2000) begin cyc(); n++; end
    if (n >= 2000) timeout("reach_100");
    led_in = 10'h000;
    run(8);
    rd(2'd2, "status_ramping");
    n = 0;
    while (m_lv[0] != 0 && n < 2000) begin cyc(); n++; end
    if (n >= 2000) timeout("reach_0");
    rd(2'd2, "status_settled");
    acc = '0;
    repeat (255) begin cyc(); acc |= led_out; end
    chk("ramped_off", 32'(acc), 32'h0);
    wr_reg(2'd1, 32'd0);
    led_in = 10'h020;
    run(262);
    wr_reg(2'd3, 32'd64);
    run(200);
    rd(2'd3, "max_rd");
    cnt = 0;
    repeat (510) begin cyc(); cnt += int'(led_out[5]); end
    chk("duty_64", 32'(cnt), 32'd128);
    wr_reg(2'd3, 32'd255);
    wr_reg(2'd0, 32'd0);
    led_in = 10'h3FF;
    run(3);
    rd(2'd2, "snap_status");
    acc = '1;
    repeat (255) begin cyc(); acc &= led_out; end
    chk("snap_all_on", 32'(acc), 32'h3FF);
    wr_reg(2'd0, 32'd1);
    wr_reg(2'd1, 32'd1);
    led_in = 10'h155;
    run(40);
    reset_n = 1'b0;
    cyc();
    chk("reset_dark", 32'(led_out), 32'h0);
    reset_n = 1'b1;
    rd(2'd1, "reset_div");
    led_in = 10'h3FF;
    n = 0;
    while (m_sc != 4 && n < 100) begin cyc(); n++; end
    if (n >= 100) timeout("step_cnt_4");
    wr_reg(2'd1, 32'd5);
    run(300);
    wr_reg(2'd1, 32'd0);
    run(20);
    wr_reg(2'd0, 32'd0);
    run(5);
    rd(2'd0, "ctrl_cleared");
    wr_reg(2'd0, 32'd1);
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 49) == 0) led_in = 10'($urandom);
      if ($urandom_range(0, 699) == 0) reset_n = 1'b0;
      else reset_n = 1'b1;
      if ($urandom_range(0, 19) == 0) begin
        address = 2'($urandom_range(0, 3));
        writedata = (address == 2'd1) ? $urandom_range(0, 3) :
                    (address == 2'd0) ? 32'($urandom_range(0, 3) != 0) : $urandom;
        chipselect = 1'b1; write_n = 1'b0;
      end else begin
        chipselect = 1'($urandom_range(0, 1)); write_n = 1'b1;
        address = 2'($urandom_range(0, 3));
      end
      #1;
      chk("rand_readdata", readdata, m_read(address));
      cyc();
      chipselect = 1'b0; write_n = 1'b1;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/nios2system_led_fader.md
# nios2system_led_fader

Downstream stage of the LED PIO in the Nios II system. Consumes the PIO's 10-bit `out_port` word and drives the physical LED pins. Each LED does not switch hard: it ramps its brightness toward on or off at a software-programmed rate and is rendered through a shared 8-bit PWM. Ramp rate, maximum brightness and fade enable are set through a small Avalon-MM slave on the same clock.

## Interface
Parameters:
- `PWM_BITS`, 8: brightness resolution; PWM period is 2^PWM_BITS−1 cycles.
- `DIV_BITS`, 16: width of the step-divider register.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  system clock.
- `reset_n`  in  1  synchronous active-low reset.
- `led_in`  in  10  requested LED state, from the LED PIO `out_port`.
- `address`  in  2  Avalon register select.
- `chipselect`  in  1  Avalon select.
- `write_n`  in  1  Avalon write strobe, active-low.
- `writedata`  in  32  Avalon write data.
- `readdata`  out  32  Avalon read data, combinational, zero-extended.
- `led_out`  out  10  PWM-modulated LED drive, registered.

## Operation
- Register map (write when `chipselect && !write_n`):
  - 0 CTRL: bit0 `fade_en`; reset 1.
  - 1 DIV: `step_div[DIV_BITS-1:0]`; reset 1000.
  - 2 STATUS: read-only; see Configuration.
  - 3 MAX: `max_level[PWM_BITS-1:0]`; reset all-ones (255).
- Unused readdata bits are 0. Writes to address 2 are ignored.
- `led_in` is registered once into `led_in_q`.
- Per-LED target: `target[i] = led_in_q[i] ? max_level : 0`.
- PWM counter: `pwm_cnt` counts 0..254, then wraps to 0. It is free-running.
  - `led_out[i] <= (pwm_cnt < level[i])`.
  - Level 0 means always off; level 255 means always on.
- Step timer: `step_cnt` counts 0..`step_div`. When `step_cnt == step_div`, it asserts `tick` for 1 cycle and returns to 0.
  - `step_div = 0` gives a tick every cycle.
  - A write to DIV clears `step_cnt` to 0 in the same cycle.
- `fade_en = 1`, on `tick`, for each LED:
  - `level < target`: `level + 1`.
  - `level > target`: `level − 1`. This also covers MAX being lowered while an LED is on.
  - `level == target`: hold.
- `fade_en = 0`: `level[i] <= target[i]` every cycle, and ticks are ignored.
- Level arithmetic is unsigned PWM_BITS wide. It never wraps, because steps are only taken toward the target.
- A `led_in` change mid-ramp reverses direction from the current level; there is no restart from an endpoint.

## Timing
- Reset values: `led_out` = 0, all `level` = 0, `pwm_cnt` = 0, `step_cnt` = 0, `led_in_q` = 0, CTRL/DIV/MAX at their reset values. `readdata` reflects reset register values.
- `reset_n` low mid-ramp: all levels and outputs are 0 on the next edge, with no residual glow.
- `led_in` → `led_in_q`: 1 cycle.
- `level` → `led_out`: 1 cycle.
- `fade_en = 0`: a `led_in` edge reaches a `led_out` effect in ≤ 3 cycles plus PWM phase.
- Full ramp 0→255 takes 255 × (`step_div` + 1) cycles.
- Register write takes effect on the edge where it is sampled; reads are the same cycle (zero wait-state).
- `tick` coincident with a CTRL write that clears `fade_en`: the snap to target wins.

## Configuration
- Macro `NIOS2SYSTEM_LED_FADER_STATUS_EN`.
- Defined: address 2 reads `{22'b0, settled[9:0]}`, where `settled[i] = (level[i] == target[i])`.
- Undefined: address 2 reads 0 and no compare logic is built. All other behaviour is identical.

## Test plan
- Reset, then read all addresses → CTRL=1, DIV=1000, MAX=255, STATUS=0x3FF (macro on); `led_out` stays 0 for 600 cycles.
- DIV=0, `led_in`=0x001 → level[0] reaches 255 after 255 ticks; `led_out[0]` is then constantly 1; other bits are 0.
- DIV=3, `led_in` 0x001 at level 100, then `led_in`=0 → level decrements from 100 and reaches 0 after 400 cycles; STATUS bit0 is 0 until then.
- MAX=64 with LED 5 fully on at 255, DIV=0 → level[5] steps down to 64. `led_out[5]` duty is then 64/255, measured over 2 full PWM periods.
- CTRL=0, `led_in`=0x3FF → all levels are 255 three cycles later with no ramp. Assert `reset_n` mid-ramp → `led_out`=0 on the next edge.
- Write DIV=5 while `step_cnt`=4 → the next tick occurs exactly 6 cycles after the write.
